// File: rtl/mem_arbiter_pkg.sv
// Shared types and port-number constants for the three-port memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arbstate_t;

    localparam logic [1:0] ARB_PORT_D = 2'd0;
    localparam logic [1:0] ARB_PORT_I = 2'd1;
    localparam logic [1:0] ARB_PORT_A = 2'd2;
    localparam logic [1:0] ARB_NONE   = 2'd3;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational winner selection; fixed priority d > i > a, or round-robin
// starting after the last grant when ARB_ROUND_ROBIN_EN is defined.
module arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic [1:0] winner
);

`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] cand;

    always_comb begin
        winner = ARB_NONE;
        // search order begins at the port after the last grant, wrapping a -> d
        cand = (last == ARB_PORT_D) ? ARB_PORT_I :
               (last == ARB_PORT_I) ? ARB_PORT_A : ARB_PORT_D;
        for (int unsigned k = 0; k < 3; k++) begin
            if (winner == ARB_NONE && req[cand]) begin
                winner = cand;
            end
            cand = (cand == ARB_PORT_A) ? ARB_PORT_D : cand + 2'd1;
        end
    end
`else
    logic unused_last;
    assign unused_last = ^last;

    always_comb begin
        if (req[0]) begin
            winner = ARB_PORT_D;
        end else if (req[1]) begin
            winner = ARB_PORT_I;
        end else if (req[2]) begin
            winner = ARB_PORT_A;
        end else begin
            winner = ARB_NONE;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Three-requester (data, instr, aux) single-outstanding memory arbiter.
// Define ARB_ROUND_ROBIN_EN for round-robin instead of fixed priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,

    input  logic        d_enable,
    input  logic [31:0] d_addr,
    input  logic [1:0]  d_oplen,
    input  logic        d_unsigned,
    input  logic        d_we,
    input  logic [31:0] d_wdata,
    output logic        d_valid,
    output logic [31:0] d_result,

    input  logic        i_enable,
    input  logic [31:0] i_addr,
    input  logic [1:0]  i_oplen,
    input  logic        i_unsigned,
    output logic        i_valid,
    output logic [31:0] i_result,

    input  logic        a_enable,
    input  logic [31:0] a_addr,
    input  logic [1:0]  a_oplen,
    input  logic        a_unsigned,
    input  logic        a_we,
    input  logic [31:0] a_wdata,
    output logic        a_valid,
    output logic [31:0] a_result,

    output logic        m_enable,
    output logic [31:0] m_addr,
    output logic        m_we,
    output logic [31:0] m_wdata,
    output logic [1:0]  m_oplen,
    output logic        m_unsigned,
    input  logic        m_valid,
    input  logic [31:0] m_result,

    output logic [1:0]  grant
);

    arbstate_t   state;
    arbstate_t   state_next;
    logic [2:0]  req;
    logic [1:0]  winner;
    logic [1:0]  last_grant;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_we;
    logic [1:0]  sel_oplen;
    logic        sel_unsigned;

    assign req = {a_enable, i_enable, d_enable};

`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] rr_last;

    // Resetting to the aux port makes the data port the first candidate.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last <= ARB_PORT_A;
        end else if (state == ARB_IDLE && req != '0) begin
            rr_last <= winner;
        end
    end

    assign last_grant = rr_last;
`else
    assign last_grant = ARB_NONE;
`endif

    arb_pick u_pick (
        .req    (req),
        .last   (last_grant),
        .winner (winner)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ARB_IDLE: if (req != '0) state_next = ARB_BUSY;
            ARB_BUSY: if (m_valid) state_next = ARB_RESP;
            ARB_RESP: state_next = ARB_IDLE;
            default:  state_next = ARB_IDLE;
        endcase
    end

    always_comb begin
        sel_addr     = d_addr;
        sel_we       = d_we;
        sel_wdata    = d_wdata;
        sel_oplen    = d_oplen;
        sel_unsigned = d_unsigned;
        case (winner)
            ARB_PORT_I: begin
                sel_addr     = i_addr;
                sel_we       = 1'b0;
                sel_wdata    = '0;
                sel_oplen    = i_oplen;
                sel_unsigned = i_unsigned;
            end
            ARB_PORT_A: begin
                sel_addr     = a_addr;
                sel_we       = a_we;
                sel_wdata    = a_wdata;
                sel_oplen    = a_oplen;
                sel_unsigned = a_unsigned;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant      <= ARB_NONE;
            m_enable   <= 1'b0;
            m_addr     <= '0;
            m_we       <= 1'b0;
            m_wdata    <= '0;
            m_oplen    <= '0;
            m_unsigned <= 1'b0;
            d_valid    <= 1'b0;
            i_valid    <= 1'b0;
            a_valid    <= 1'b0;
            d_result   <= '0;
            i_result   <= '0;
            a_result   <= '0;
        end else begin
            d_valid <= 1'b0;
            i_valid <= 1'b0;
            a_valid <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (req != '0) begin
                        grant      <= winner;
                        m_enable   <= 1'b1;
                        m_addr     <= sel_addr;
                        m_we       <= sel_we;
                        m_wdata    <= sel_wdata;
                        m_oplen    <= sel_oplen;
                        m_unsigned <= sel_unsigned;
                    end
                end
                ARB_BUSY: begin
                    if (m_valid) begin
                        m_enable <= 1'b0;
                        case (grant)
                            ARB_PORT_D: begin d_valid <= 1'b1; d_result <= m_result; end
                            ARB_PORT_I: begin i_valid <= 1'b1; i_result <= m_result; end
                            ARB_PORT_A: begin a_valid <= 1'b1; a_result <= m_result; end
                            default: ;
                        endcase
                    end
                end
                ARB_RESP: grant <= ARB_NONE;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run against a transaction-level arbitration model.
`timescale 1ns/1ps
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  en;
    logic [31:0] addr  [3];
    logic [1:0]  oplen [3];
    logic        uns   [3];
    logic        we    [3];
    logic [31:0] wdata [3];
    logic [2:0]  valid;
    logic [31:0] res   [3];
    logic        m_enable, m_we, m_unsigned, m_valid;
    logic [31:0] m_addr, m_wdata, m_result;
    logic [1:0]  m_oplen, grant;

    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .d_enable(en[0]), .d_addr(addr[0]), .d_oplen(oplen[0]), .d_unsigned(uns[0]),
        .d_we(we[0]), .d_wdata(wdata[0]), .d_valid(valid[0]), .d_result(res[0]),
        .i_enable(en[1]), .i_addr(addr[1]), .i_oplen(oplen[1]), .i_unsigned(uns[1]),
        .i_valid(valid[1]), .i_result(res[1]),
        .a_enable(en[2]), .a_addr(addr[2]), .a_oplen(oplen[2]), .a_unsigned(uns[2]),
        .a_we(we[2]), .a_wdata(wdata[2]), .a_valid(valid[2]), .a_result(res[2]),
        .m_enable(m_enable), .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata),
        .m_oplen(m_oplen), .m_unsigned(m_unsigned), .m_valid(m_valid), .m_result(m_result),
        .grant(grant)
    );

`ifdef ARB_ROUND_ROBIN_EN
    int model_last;

    // Picks the first requester after the previously granted one and remembers it.
    function automatic int ref_pick(input logic [2:0] r);
        for (int k = 1; k <= 3; k++) begin
            if (r[(model_last + k) % 3]) begin
                model_last = (model_last + k) % 3;
                return model_last;
            end
        end
        return 3;
    endfunction
`else
    function automatic int ref_pick(input logic [2:0] r);
        for (int k = 0; k < 3; k++) begin
            if (r[k]) return k;
        end
        return 3;
    endfunction
`endif

    task automatic do_reset();
        rst = 1'b1;
        en = '0;
        m_valid = 1'b0;
        m_result = '0;
        for (int p = 0; p < 3; p++) begin
            addr[p] = '0; oplen[p] = '0; uns[p] = 1'b0; we[p] = 1'b0; wdata[p] = '0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        model_last = 2;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en = 3'b111;
        m_valid = 1'b1;
        m_result = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        n_cmp++; if (grant !== 2'd3) begin n_fail++; $display("FAIL reset_grant: got %0d expected 3", grant); end
        n_cmp++; if (m_enable !== 1'b0) begin n_fail++; $display("FAIL reset_m_enable: got %b expected 0", m_enable); end
        n_cmp++; if ({m_addr, m_wdata, m_we, m_oplen, m_unsigned} !== '0) begin n_fail++; $display("FAIL reset_m_fields: got %h/%h/%b/%0d/%b expected zeros", m_addr, m_wdata, m_we, m_oplen, m_unsigned); end
        n_cmp++; if (valid !== 3'b000) begin n_fail++; $display("FAIL reset_valid: got %b expected 000", valid); end
        n_cmp++; if ({res[0], res[1], res[2]} !== '0) begin n_fail++; $display("FAIL reset_result: got %h %h %h expected 0", res[0], res[1], res[2]); end
        do_reset();
    endtask

    task automatic test_read_i();
        do_reset();
        en[1] = 1'b1; addr[1] = 32'h0000_0010; oplen[1] = 2'd2; uns[1] = 1'b1;
        @(negedge clk);
        n_cmp++; if (m_enable !== 1'b1) begin n_fail++; $display("FAIL read_m_enable: got %b expected 1", m_enable); end
        n_cmp++; if (grant !== 2'd1) begin n_fail++; $display("FAIL read_grant: got %0d expected 1", grant); end
        n_cmp++; if (m_addr !== 32'h10) begin n_fail++; $display("FAIL read_m_addr: got %h expected 00000010", m_addr); end
        n_cmp++; if ({m_we, m_oplen, m_unsigned} !== 4'b0_10_1) begin n_fail++; $display("FAIL read_m_ctrl: got we=%b oplen=%0d uns=%b expected 0/2/1", m_we, m_oplen, m_unsigned); end
        @(negedge clk);
        n_cmp++; if (m_enable !== 1'b1) begin n_fail++; $display("FAIL read_hold: got %b expected 1", m_enable); end
        m_valid = 1'b1; m_result = 32'h0000_0013;
        @(negedge clk);
        m_valid = 1'b0;
        n_cmp++; if (valid !== 3'b010) begin n_fail++; $display("FAIL read_valid: got %b expected 010", valid); end
        n_cmp++; if (res[1] !== 32'h13) begin n_fail++; $display("FAIL read_result: got %h expected 00000013", res[1]); end
        n_cmp++; if (m_enable !== 1'b0) begin n_fail++; $display("FAIL read_m_drop: got %b expected 0", m_enable); end
        en[1] = 1'b0;
        @(negedge clk);
        n_cmp++; if (valid !== 3'b000) begin n_fail++; $display("FAIL read_valid_once: got %b expected 000", valid); end
        n_cmp++; if (grant !== 2'd3) begin n_fail++; $display("FAIL read_grant_none: got %0d expected 3", grant); end
        n_cmp++; if (res[1] !== 32'h13) begin n_fail++; $display("FAIL read_result_hold: got %h expected 00000013", res[1]); end
    endtask

    task automatic test_priority();
        do_reset();
        en[0] = 1'b1; addr[0] = 32'h200; we[0] = 1'b1; wdata[0] = 32'h55AA_55AA; oplen[0] = 2'd1;
        en[1] = 1'b1; addr[1] = 32'h300;
        @(negedge clk);
        n_cmp++; if (grant !== 2'd0) begin n_fail++; $display("FAIL prio_first: got %0d expected 0", grant); end
        n_cmp++; if (m_addr !== 32'h200 || m_we !== 1'b1) begin n_fail++; $display("FAIL prio_d_fields: got %h/%b expected 00000200/1", m_addr, m_we); end
        m_valid = 1'b1; m_result = 32'hA1;
        @(negedge clk);
        m_valid = 1'b0;
        n_cmp++; if (valid !== 3'b001 || res[0] !== 32'hA1) begin n_fail++; $display("FAIL prio_d_done: got %b/%h expected 001/000000a1", valid, res[0]); end
        en[0] = 1'b0;
        @(negedge clk);
        n_cmp++; if (grant !== 2'd3 || valid !== 3'b000) begin n_fail++; $display("FAIL prio_gap: got %0d/%b expected 3/000", grant, valid); end
        @(negedge clk);
        n_cmp++; if (grant !== 2'd1 || m_enable !== 1'b1) begin n_fail++; $display("FAIL prio_second: got %0d/%b expected 1/1", grant, m_enable); end
        n_cmp++; if (m_addr !== 32'h300 || m_we !== 1'b0 || m_wdata !== 32'h0) begin n_fail++; $display("FAIL prio_i_fields: got %h/%b/%h expected 00000300/0/00000000", m_addr, m_we, m_wdata); end
        m_valid = 1'b1; m_result = 32'hB2;
        @(negedge clk);
        m_valid = 1'b0;
        n_cmp++; if (valid !== 3'b010 || res[1] !== 32'hB2 || res[0] !== 32'hA1) begin n_fail++; $display("FAIL prio_i_done: got %b/%h/%h expected 010/000000b2/000000a1", valid, res[1], res[0]); end
        en[1] = 1'b0;
        @(negedge clk);
        n_cmp++; if (valid !== 3'b000 || grant !== 2'd3) begin n_fail++; $display("FAIL prio_end: got %b/%0d expected 000/3", valid, grant); end
    endtask

    task automatic test_write();
        do_reset();
        en[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h100; wdata[0] = 32'hDEAD_BEEF; oplen[0] = 2'd2; uns[0] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (m_enable !== 1'b1 || m_we !== 1'b1 || m_wdata !== 32'hDEAD_BEEF || m_addr !== 32'h100 || m_oplen !== 2'd2) begin
                n_fail++;
                $display("FAIL write_hold[%0d]: got en=%b we=%b wdata=%h addr=%h oplen=%0d expected 1/1/deadbeef/00000100/2", c, m_enable, m_we, m_wdata, m_addr, m_oplen);
            end
            addr[0] = 32'h0BAD_0000 + c; wdata[0] = 32'h0;
        end
        m_valid = 1'b1; m_result = 32'h77;
        @(negedge clk);
        m_valid = 1'b0;
        n_cmp++; if (valid !== 3'b001 || res[0] !== 32'h77) begin n_fail++; $display("FAIL write_done: got %b/%h expected 001/00000077", valid, res[0]); end
        en[0] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++; if (valid !== 3'b000) begin n_fail++; $display("FAIL write_once[%0d]: got %b expected 000", c, valid); end
        end
    endtask

    task automatic test_reset_busy();
        en[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h4000; wdata[2] = 32'h1234;
        @(negedge clk);
        n_cmp++; if (m_enable !== 1'b1 || grant !== 2'd2) begin n_fail++; $display("FAIL rstbusy_start: got %b/%0d expected 1/2", m_enable, grant); end
        rst = 1'b1; m_valid = 1'b1; m_result = 32'hCAFE;
        @(negedge clk);
        n_cmp++; if (m_enable !== 1'b0 || grant !== 2'd3) begin n_fail++; $display("FAIL rstbusy_abort: got %b/%0d expected 0/3", m_enable, grant); end
        n_cmp++; if (valid !== 3'b000 || {res[0], res[1], res[2]} !== '0) begin n_fail++; $display("FAIL rstbusy_outputs: got %b %h %h %h expected 000 0 0 0", valid, res[0], res[1], res[2]); end
        rst = 1'b0; m_valid = 1'b0; en[2] = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        model_last = 2;
`endif
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++; if (valid !== 3'b000 || m_enable !== 1'b0) begin n_fail++; $display("FAIL rstbusy_quiet[%0d]: got %b/%b expected 000/0", c, valid, m_enable); end
        end
    endtask

    task automatic test_mvalid_idle();
        m_valid = 1'b1; m_result = 32'h0BAD;
        @(negedge clk);
        m_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            n_cmp++; if (valid !== 3'b000 || m_enable !== 1'b0 || grant !== 2'd3) begin n_fail++; $display("FAIL idle_mvalid[%0d]: got %b/%b/%0d expected 000/0/3", c, valid, m_enable, grant); end
            @(negedge clk);
        end
        en[1] = 1'b1; addr[1] = 32'h44;
        @(negedge clk);
        n_cmp++; if (m_enable !== 1'b1 || grant !== 2'd1) begin n_fail++; $display("FAIL idle_then_req: got %b/%0d expected 1/1", m_enable, grant); end
        m_valid = 1'b1; m_result = 32'h99;
        @(negedge clk);
        m_valid = 1'b0;
        n_cmp++; if (valid !== 3'b010 || res[1] !== 32'h99) begin n_fail++; $display("FAIL idle_then_done: got %b/%h expected 010/00000099", valid, res[1]); end
        en[1] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_drop_mid();
        do_reset();
        en[2] = 1'b1; addr[2] = 32'h500; we[2] = 1'b0;
        @(negedge clk);
        en[2] = 1'b0;
        n_cmp++; if (m_enable !== 1'b1 || grant !== 2'd2) begin n_fail++; $display("FAIL drop_start: got %b/%0d expected 1/2", m_enable, grant); end
        @(negedge clk);
        n_cmp++; if (m_enable !== 1'b1 || grant !== 2'd2) begin n_fail++; $display("FAIL drop_hold: got %b/%0d expected 1/2", m_enable, grant); end
        m_valid = 1'b1; m_result = 32'h5A;
        @(negedge clk);
        m_valid = 1'b0;
        n_cmp++; if (valid !== 3'b100 || res[2] !== 32'h5A) begin n_fail++; $display("FAIL drop_done: got %b/%h expected 100/0000005a", valid, res[2]); end
        @(negedge clk);
        n_cmp++; if (valid !== 3'b000 || grant !== 2'd3) begin n_fail++; $display("FAIL drop_end: got %b/%0d expected 000/3", valid, grant); end
        @(negedge clk);
        n_cmp++; if (m_enable !== 1'b0) begin n_fail++; $display("FAIL drop_regrant: got %b expected 0", m_enable); end
    endtask

    task automatic test_back_to_back();
        int exp_seq [6];
        int got = 0;
        int unsigned cyc = 0;
`ifdef ARB_ROUND_ROBIN_EN
        exp_seq = '{0, 1, 2, 0, 1, 2};
`else
        exp_seq = '{0, 0, 0, 0, 0, 0};
`endif
        do_reset();
        for (int p = 0; p < 3; p++) addr[p] = 32'h1000 * (p + 1);
        en = 3'b111;
        while (got < 6 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            m_valid = 1'b0;
            if (m_enable === 1'b1) begin
                n_cmp++; if (grant !== 2'(exp_seq[got])) begin n_fail++; $display("FAIL b2b_grant[%0d]: got %0d expected %0d", got, grant, exp_seq[got]); end
                got++;
                m_valid = 1'b1; m_result = 32'(cyc);
            end
        end
        n_cmp++; if (got != 6) begin n_fail++; $display("FAIL b2b_timeout: got %0d grants expected 6", got); end
        en = '0;
        @(negedge clk);
        m_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random(input int unsigned n_txn);
        int unsigned done_n = 0;
        int unsigned cyc = 0;
        int unsigned wait_left = 0;
        int cur = 3;
        bit resp_pending = 1'b0;
        logic [31:0] resp_val = '0;
        logic [31:0] last_res [3];
        logic prev_men = 1'b0;
        logic [2:0] exp_v;
        do_reset();
        for (int p = 0; p < 3; p++) last_res[p] = '0;
        while (done_n < n_txn && cyc < 20 * n_txn + 100) begin
            @(negedge clk);
            cyc++;
            exp_v = '0;
            if (resp_pending && cur < 3) begin
                exp_v[cur] = 1'b1;
                last_res[cur] = resp_val;
            end
            n_cmp++; if (valid !== exp_v) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b expected %b", cyc, valid, exp_v); end
            for (int p = 0; p < 3; p++) begin
                n_cmp++; if (res[p] !== last_res[p]) begin n_fail++; $display("FAIL rnd_result[%0d]@%0d: got %h expected %h", p, cyc, res[p], last_res[p]); end
            end
            if (m_enable === 1'b1 && prev_men === 1'b0) begin
                cur = ref_pick(en);
                n_cmp++; if (grant !== 2'(cur)) begin n_fail++; $display("FAIL rnd_grant@%0d: got %0d expected %0d", cyc, grant, cur); end
                if (cur < 3) begin
                    n_cmp++;
                    if (m_addr !== addr[cur] || m_oplen !== oplen[cur] || m_unsigned !== uns[cur] ||
                        m_we !== (cur == 1 ? 1'b0 : we[cur]) || m_wdata !== (cur == 1 ? 32'h0 : wdata[cur])) begin
                        n_fail++;
                        $display("FAIL rnd_fields@%0d: got addr=%h we=%b wdata=%h for port %0d expected addr=%h", cyc, m_addr, m_we, m_wdata, cur, addr[cur]);
                    end
                end
                wait_left = $urandom_range(0, 3);
            end
            prev_men = m_enable;
            if (resp_pending) begin
                if (cur < 3) en[cur] = 1'b0;
                done_n++;
                resp_pending = 1'b0;
                m_valid = 1'b0;
                cur = 3;
            end else if (m_enable === 1'b1 && cur < 3) begin
                if (wait_left == 0) begin
                    m_result = $urandom;
                    resp_val = m_result;
                    m_valid = 1'b1;
                    resp_pending = 1'b1;
                end else begin
                    wait_left--;
                end
            end
            for (int p = 0; p < 3; p++) begin
                if (en[p] === 1'b0 && p != cur && $urandom_range(0, 2) == 0) begin
                    en[p] = 1'b1;
                    addr[p] = $urandom;
                    oplen[p] = 2'($urandom);
                    uns[p] = 1'($urandom);
                    we[p] = 1'($urandom);
                    wdata[p] = $urandom;
                end
            end
        end
        n_cmp++; if (done_n < n_txn) begin n_fail++; $display("FAIL rnd_timeout: got %0d completions expected %0d", done_n, n_txn); end
        en = '0;
        m_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        en = '0;
        m_valid = 1'b0;
        m_result = '0;
        for (int p = 0; p < 3; p++) begin
            addr[p] = '0; oplen[p] = '0; uns[p] = 1'b0; we[p] = 1'b0; wdata[p] = '0;
        end
        test_reset();
        test_read_i();
        test_priority();
        test_write();
        test_reset_busy();
        test_mvalid_idle();
        test_drop_mid();
        test_back_to_back();
        test_random(80);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
